// File: rtl/itype_wb_scoreboard.sv
// Bench-side checker: replays the I-type instruction stream on a shadow register file
// and compares the expected (rd, value) writebacks, in order, with the core's writeback port.
module itype_wb_scoreboard #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int DEPTH     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   instr_valid,
  input  logic [31:0]            instr,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  input  logic [WORD_SIZE-1:0]   wb_data,
  input  logic                   init_we,
  input  logic [4:0]             init_idx,
  input  logic [WORD_SIZE-1:0]   init_data,
  output logic                   mismatch,
  output logic                   unexpected,
  output logic                   overflow,
  output logic                   err_sticky,
  output logic [31:0]            checked_count,
  output logic [15:0]            mismatch_count,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [6:0]    OP_IMM   = 7'b0010011;

  logic [WORD_SIZE-1:0] regs [NUM_REGS];

  logic [4:0]                  rs1;
  logic [4:0]                  rd;
  logic [4:0]                  shamt;
  logic [2:0]                  funct3;
  logic [WORD_SIZE-1:0]        imm;
  logic [WORD_SIZE-1:0]        src;
  logic signed [WORD_SIZE-1:0] src_s;
  logic [WORD_SIZE-1:0]        sra_val;
  logic [WORD_SIZE-1:0]        result;

  assign rs1    = instr[19:15];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign shamt  = instr[24:20];
  assign imm    = {{(WORD_SIZE-12){instr[31]}}, instr[31:20]};
  assign src    = (rs1 == 5'd0) ? '0 : regs[rs1];

  // Arithmetic shift computed on its own so the signed context is not lost in a mixed-sign select.
  always_comb begin
    src_s   = $signed(src);
    sra_val = src_s >>> shamt;
    result  = '0;
    case (funct3)
      3'd0: result = src + imm;
      3'd1: result = src << shamt;
      3'd2: result = {{(WORD_SIZE-1){1'b0}}, ($signed(src) < $signed(imm))};
      3'd3: result = {{(WORD_SIZE-1){1'b0}}, (src < imm)};
      3'd4: result = src ^ imm;
      3'd5: begin
        if (instr[30]) result = sra_val;
        else           result = src >> shamt;
      end
      3'd6: result = src | imm;
      3'd7: result = src & imm;
      default: result = '0;
    endcase
  end

  logic                 is_op;
  logic                 enq;
  logic                 cmp;
  logic                 pop;
  logic                 push;
  logic                 full;
  logic                 empty;
  logic                 differ;
  logic [WORD_SIZE+4:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;

  assign is_op  = instr_valid && (instr[6:0] == OP_IMM);
  assign enq    = is_op && (rd != 5'd0);
  assign cmp    = wb_valid && (wb_rd != 5'd0);
  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign pop    = cmp && !empty;
  assign push   = enq && (!full || pop);
  assign differ = (mem[rd_ptr] != {wb_rd, wb_data});

  // Shadow state is never reset, like the core's register file; a seed write beats an instruction update.
  always_ff @(posedge clk) begin
    if (is_op && !reset) regs[rd] <= result;
    if (init_we)         regs[init_idx] <= init_data;
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= {rd, result};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      mismatch       <= 1'b0;
      unexpected     <= 1'b0;
      overflow       <= 1'b0;
      err_sticky     <= 1'b0;
      checked_count  <= '0;
      mismatch_count <= '0;
    end else begin
      mismatch   <= 1'b0;
      unexpected <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
      if (enq && full && !pop) begin
        overflow   <= 1'b1;
        err_sticky <= 1'b1;
      end
      // No bypass: a writeback against an empty queue is unexpected even if an entry lands this edge.
      if (pop) begin
        if (checked_count != '1) checked_count <= checked_count + 32'd1;
        if (differ) begin
          mismatch   <= 1'b1;
          err_sticky <= 1'b1;
          if (mismatch_count != '1) mismatch_count <= mismatch_count + 16'd1;
        end
      end else if (cmp) begin
        unexpected <= 1'b1;
        err_sticky <= 1'b1;
        if (mismatch_count != '1) mismatch_count <= mismatch_count + 16'd1;
      end
    end
  end

  assign pending = count;

endmodule

// File: doc/itype_wb_scoreboard.md
# itype_wb_scoreboard

Checker for the sodor5 verification bench that consumes the same I-type instruction stream driven into the core's instruction port. It decodes each word, executes it against a shadow register file and queues the expected `(rd, value)` writeback. It then compares that queue, in order, against the core's register writeback port and flags mismatches, unexpected writebacks and queue overflow. The block sits beside the core in the bench top and has no effect on the DUT.

## Interface

Parameters:
- `WORD_SIZE`, default 32: data width.
- `NUM_REGS`, default 32: shadow register count. The index width is 5.
- `DEPTH`, default 8: expected-writeback FIFO entries. Must be a power of 2 and at least 2.

Ports:
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `instr_valid` input, 1 bit: `instr` is fetched this cycle.
- `instr` input, 32 bits: instruction word, same bits as the core's imem response data.
- `wb_valid` input, 1 bit: the core writes its register file this cycle.
- `wb_rd` input, 5 bits: writeback destination.
- `wb_data` input, `WORD_SIZE` bits: writeback value.
- `init_we` input, 1 bit: shadow register seed write enable.
- `init_idx` input, 5 bits: seed index.
- `init_data` input, `WORD_SIZE` bits: seed value.
- `mismatch` output, 1 bit: one-cycle pulse. The compared rd or data differed.
- `unexpected` output, 1 bit: one-cycle pulse. A writeback arrived while the FIFO was empty.
- `overflow` output, 1 bit: sticky. An enqueue was dropped because the FIFO was full.
- `err_sticky` output, 1 bit: OR of every mismatch, unexpected and overflow event since reset.
- `checked_count` output, 32 bits: number of compares, saturating.
- `mismatch_count` output, 16 bits: number of mismatch plus unexpected events, saturating.
- `pending` output, log2(`DEPTH`)+1 bits: current FIFO occupancy.

## Operation

Decode:
- Only `instr[6:0] == 7'b0010011` is acted on. All other opcodes are ignored.
- Fields: `imm = sext(instr[31:20])`, `rs1 = instr[19:15]`, `funct3 = instr[14:12]`, `rd = instr[11:7]`.

Execute, by `funct3`:
- 0: ADDI, `a + imm`, mod 2^32.
- 2: SLTI, signed compare, result 1 or 0.
- 3: SLTIU, unsigned compare against the sign-extended imm, result 1 or 0.
- 4: XORI.
- 6: ORI.
- 7: ANDI.
- 1: SLLI, shift amount `instr[24:20]`.
- 5: SRAI when `instr[30] == 1`, else SRLI. Shift amount `instr[24:20]`.
- Bits `instr[31:25]` other than bit 30 are ignored for shifts.

Shadow register file:
- Reads of x0 return 0 regardless of seeded contents.
- The shadow register is updated with the result at the same edge as the enqueue. The next instruction therefore sees program-order state, with no hazard window.
- An `init_we` write and an instruction update to the same register in the same cycle: `init_we` wins.
- Writes to index 0 are stored but never read.

Enqueue:
- A valid I-type with `rd != 0` enqueues `{rd, result}`.
- `rd == 0` enqueues nothing and covers the 0x00000013 NOP.

Dequeue and compare:
- `wb_valid && wb_rd != 0` is a compare event. `wb_rd == 0` writebacks are ignored.
- FIFO non-empty: pop the head and compare it with `{wb_rd, wb_data}`. `checked_count` is incremented on every compare. Any difference sets `mismatch` and increments `mismatch_count`.
- FIFO empty: nothing is popped. `unexpected` is set and `mismatch_count` is incremented. This holds even if an enqueue occurs in the same cycle; there is no bypass.
- Full FIFO with an enqueue and no dequeue: the entry is dropped and `overflow` is set.
- Full FIFO with simultaneous enqueue and dequeue: both proceed and occupancy stays at `DEPTH`.
- Pointers wrap modulo `DEPTH`. Occupancy is tracked with one extra bit so full and empty are distinguishable.

## Timing

- Decode and execute are combinational from `instr` and shadow state. The enqueue and shadow update are registered at the edge where `instr_valid` is high.
- An entry enqueued at edge N can be compared at edge N+1 at the earliest.
- `mismatch` and `unexpected` are registered. They are high for exactly the cycle after the compare edge.
- Counters and `pending` are visible in the cycle after the edge that changes them.
- Reset, including mid-run:
  - FIFO flushed, so `pending = 0`.
  - All flags and counters cleared to 0.
  - Shadow register file not cleared, matching the unreset core register file.
- `init_we` is honoured both during and after reset.

## Test plan

- Seed x1=5. Send 0xFFD08113 (ADDI x2,x1,-3), then `wb x2 = 2` on the next cycle. Required: `checked_count = 1`, `mismatch = 0`, `pending` goes 1 then 0.
- Seed x1=0x80000000. Send 0x4040D193 (SRAI x3,x1,4), then `wb x3 = 0xF8000000`. Required: pass. Then `wb x3 = 0x08000000`: required `unexpected = 1`, since the queue is empty.
- Seed x0=0xDEADBEEF. Send 0x00103213 (SLTIU x4,x0,1). Expected value is 1. Send `wb x4 = 0` instead: required `mismatch` pulse and `mismatch_count = 1`.
- Send 9 ADDI instructions with `rd != 0` and no writebacks. Required: `pending = 8`, `overflow = 1`, `err_sticky = 1`. Draining 8 correct writebacks gives `checked_count = 8` with no mismatch.
- Stream 0x00000013 NOPs only. Required: `pending` stays 0. A `wb` with `rd = 0` produces no flags.
- Enqueue 3 entries, assert `reset` for one cycle, then send 1 correct instruction/writeback pair. Required: `pending = 0` after reset, counters 0, the post-reset compare passes, and the shadow register values are preserved.
